spi_rx: RTL

// - SPI receive end of the team's 24-bit SPI link: samples spi_cs/spi_clk/spi_data with the system clock.
// - Reassembles MSB-first words and hands each completed word to a downstream consumer over a valid/ready handshake.
// - Used as the loopback/peer endpoint of the spi_tx path and as the front end of the board-side register decoder.

---
 rtl/spi_rx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/spi_rx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_rx
//  Description : SPI receive endpoint. Synchronizes spi_cs/spi_clk/spi_data
//                into the clk domain, reassembles MSB-first DATA_W-bit words
//                and presents them through a 1-entry valid/ready buffer.
//                Flags truncated or over-long frames and dropped words.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_rx #(
    parameter int DATA_W      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              RSTn,
    input  logic              spi_cs,
    input  logic              spi_clk,
    input  logic              spi_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int             c_cnt_w = $clog2(DATA_W + 1);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_W - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_recv = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_sclk_prev;

    logic [1:0]             r_state;
    logic [c_cnt_w-1:0]     r_bit_cnt;
    logic [DATA_W-1:0]      r_shift;
    logic                   r_load;
    logic                   r_frame_err;

    logic [DATA_W-1:0]      r_rx_data;
    logic                   r_rx_valid;
    logic                   r_overrun;

    logic                   w_cs_s;
    logic                   w_clk_s;
    logic                   w_data_s;
    logic                   w_sclk_rise;

    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_clk_s     = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s    = r_data_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_clk_s & ~r_sclk_prev;

    // Multi-flop synchronizers on the asynchronous SPI pins, plus the
    // previous synced spi_clk for rising-edge detection.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_cs_sync   <= '1;
            r_clk_sync  <= '0;
            r_data_sync <= '0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], spi_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], spi_data};
            r_sclk_prev <= w_clk_s;
        end
    end

    // Frame FSM: shifts bits in while cs is low, raises a one-cycle load
    // request on the last bit and flags truncated or over-long frames.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_state     <= c_idle;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_load      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_load      <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (!w_cs_s) begin
                        r_state   <= c_recv;
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                    end
                end
                c_recv: begin
                    if (w_cs_s) begin
                        // cs rising before any bit is just an empty window
                        r_frame_err <= (r_bit_cnt != '0);
                        r_state     <= c_idle;
                    end else if (w_sclk_rise) begin
                        r_shift   <= {r_shift[DATA_W-2:0], w_data_s};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_last_bit) begin
                            r_state <= c_done;
                            r_load  <= 1'b1;
                        end
                    end
                end
                c_done: begin
                    // bit_cnt is left at DATA_W; extra edges only raise errors
                    if (w_cs_s) begin
                        r_state <= c_idle;
                    end else if (w_sclk_rise) begin
                        r_frame_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    // One-entry output buffer: a completed word replaces an accepted one in
    // the same cycle, but is dropped (and overrun set) if the old word stays.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (r_load) begin
            if (!r_rx_valid || rx_ready) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else begin
                r_overrun  <= 1'b1;
            end
        end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != c_idle);

endmodule
`default_nettype wire
